adder4_bist: RTL and testbench
==============================

Name: adder4_bist

Overview:
- Built-in self-test engine for the 4-bit ripple-carry adder (`adder4_ripple_carry`). It sits at the adder's input/output boundary.
- It drives a, b and cin, and samples sum and cout.
- It sweeps every operand combination exhaustively and checks each result against an internal reference sum.
- It reports pass/fail, an error count and the first failing vector. This is the synthesizable replacement for the hand-written adder vector list.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- SETTLE_CYCLES, 2, clock cycles allowed for the carry chain to settle before sampling; legal values are 1 or more.
- ERR_W, 10, width of the error counter; the counter saturates.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a test; honoured only in IDLE or DONE.
- a_o  out  WIDTH  operand a to the adder; registered.
- b_o  out  WIDTH  operand b to the adder; registered.
- cin_o  out  1  carry-in to the adder; registered.
- sum_i  in  WIDTH  sum from the adder.
- cout_i  in  1  carry-out from the adder.
- busy  out  1  high while in APPLY, SETTLE or CHECK.
- done  out  1  held high in DONE; cleared by start or reset.
- pass  out  1  valid when done=1; equals 1 if err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating at 2^ERR_W-1.
- first_fail  out  2*WIDTH+1  the {a,b,cin} of the first mismatch; 0 if there was none.

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - state goes to IDLE.
  - a_o, b_o, cin_o, the vector index, err_count, first_fail, busy, done and pass all go to 0.
- Vector index idx is 2*WIDTH+1 bits wide, with {a_o,b_o,cin_o} = idx, so cin is the LSB. The sweep runs idx 0 to 2^(2*WIDTH+1)-1 (512 vectors by default).
- IDLE:
  - On start: clear idx, err_count and first_fail, then go to APPLY.
- APPLY (1 cycle):
  - Register a_o, b_o and cin_o from idx, then go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles):
  - A down-counter loaded on entry; the outputs are held stable.
  - When the counter expires, go to CHECK.
- CHECK (1 cycle):
  - Compare {cout_i,sum_i} with a_o+b_o+cin_o computed at WIDTH+1 bits.
  - On a mismatch: err_count increments unless saturated. If err_count was 0, capture idx into first_fail.
  - If idx is at its maximum, go to DONE; otherwise increment idx and go to APPLY.
- Timing:
  - Each vector takes exactly SETTLE_CYCLES+2 cycles.
  - done rises (SETTLE_CYCLES+2)*2^(2*WIDTH+1) cycles after the cycle in which start was sampled.
  - Default: 4*512 = 2048 cycles.
- DONE:
  - Outputs, err_count and first_fail are held.
  - pass = (err_count==0).
  - start restarts the sweep; done drops in the next cycle.
- start while busy is ignored.
- There is no idx wrap: the sweep terminates at the maximum index.
- busy and done are never both high.

Optional Feature:
- Macro: ADDER_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK sends the FSM directly to DONE. err_count ends at 1, first_fail holds the failing idx, and a_o/b_o/cin_o stay on the failing vector for debug.
- Undefined: the sweep always runs to completion as described above.

Decomposition:
- Shared package adder_bist_pkg holds:
  - the state enum IDLE/APPLY/SETTLE/CHECK/DONE;
  - a function computing the reference sum;
  - the localparam VEC_W = 2*WIDTH+1.
- One natural sub-module, adder_bist_settle_cnt: the loadable down-counter with an expire flag, used by SETTLE.
- The comparator and error logic stay inline.

Test Plan:
- Correct adder connected, start pulsed -> done=1 after exactly 2048 cycles; pass=1, err_count=0, first_fail=0; busy high throughout the sweep.
- Adder with sum[0] stuck at 0 -> err_count=256, first_fail=9'b000000001 (a=0, b=0, cin=1), pass=0.
- Adder with cout stuck at 0 -> err_count=256, first_fail=9'd31 (a=0, b=15, cin=1).
- Same cout fault with ERR_W=8 -> err_count saturates at 255, pass=0.
- rst_n asserted at idx=100 mid-SETTLE -> all outputs 0 immediately (asynchronous); a subsequent start reruns the full sweep with correct results. start pulsed during the sweep has no effect.
- With ADDER_BIST_STOP_ON_FAIL_EN and sum[0] stuck at 0 -> done at cycle 8; err_count=1, first_fail=1; a_o=0, b_o=0, cin_o=1 held.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST engine: FSM state encoding,
// default vector width and the golden sum used by the result comparator.
package adder_bist_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int VEC_W     = 2*WIDTH_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Operands are zero-extended to 32 bits so one function serves any WIDTH <= 32.
    function automatic logic [32:0] ref_sum(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
        ref_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

endpackage

// File: rtl/adder_bist_settle_cnt.sv
// Loadable down-counter timing the adder settle window; expired is high at count 0.
// Latency: load gives CNT_MAX cycles before expiry. No backpressure: en simply pauses it.
// Loading CNT_MAX-1 makes expired assert on the CNT_MAX-th enabled cycle.
module adder_bist_settle_cnt #(
    parameter int CNT_MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CNT_MAX - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/adder4_bist.sv
// Exhaustive self-test of a ripple-carry adder: sweeps {a,b,cin}, counts mismatches, keeps first failure.
// Latency: SETTLE_CYCLES+2 cycles per vector; start is ignored while busy (no other backpressure).
// ADDER_BIST_STOP_ON_FAIL_EN: when defined, the first mismatch ends the sweep with the failing vector held.
module adder4_bist
    import adder_bist_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 cin_o,
    input  logic [WIDTH-1:0]     sum_i,
    input  logic                 cout_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int IDX_W = 2*WIDTH + 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   ff_q, ff_d;

    logic               settle_expired;
    logic [32:0]        ref_full;
    logic [32:0]        got_full;
    logic               mismatch;
    logic               stop_now;

    adder_bist_settle_cnt #(
        .CNT_MAX (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_q == ST_APPLY),
        .en      (state_q == ST_SETTLE),
        .expired (settle_expired)
    );

    assign a_o   = vec_q[IDX_W-1 -: WIDTH];
    assign b_o   = vec_q[WIDTH:1];
    assign cin_o = vec_q[0];

    assign ref_full = ref_sum(32'(a_o), 32'(b_o), cin_o);
    assign got_full = {{(32-WIDTH){1'b0}}, cout_i, sum_i};
    assign mismatch = (got_full != ref_full);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                vec_d   = idx_q;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    // First failure is latched only while the count is still zero.
                    if (err_q == '0) begin
                        ff_d = idx_q;
                    end
                end
                if (stop_now || (idx_q == '1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign busy       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_adder4_bist.sv
// Bench for adder4_bist: a faultable behavioural adder sits under two DUTs (ERR_W 10 and 8);
// expected sweep results come from an exhaustive reference loop and are scored when done rises.
module tb_adder4_bist;

    localparam int S    = 2;
    localparam int NVEC = 512;

    typedef struct {
        int t0;
        int lat;
        int err0;
        int err1;
        int ff;
        int vec;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;

    logic [3:0] a0, b0, sum0, a1, b1, sum1;
    logic       cin0, cout0, cin1, cout1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [9:0] err0;
    logic [7:0] err1;
    logic [8:0] ff0, ff1;

    int fault_kind = 0;
    int f_bit = 0;
    int f_val = 0;
    int f_a = 0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_gap = 0;
    int   overlap = 0;
    logic done_prev = 1'b0;
    exp_t exp_q[$];
    exp_t mon_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test, with an optional injected fault.
    function automatic logic [4:0] env_adder(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(c);
        case (fault_kind)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: r[f_bit] = f_val[0];
            4: if (a == 4'(f_a)) r[f_bit] = ~r[f_bit];
            default: ;
        endcase
        return r;
    endfunction

    assign {cout0, sum0} = env_adder(a0, b0, cin0);
    assign {cout1, sum1} = env_adder(a1, b1, cin1);

    adder4_bist #(.WIDTH(4), .SETTLE_CYCLES(S), .ERR_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a0), .b_o(b0), .cin_o(cin0), .sum_i(sum0), .cout_i(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
    );

    adder4_bist #(.WIDTH(4), .SETTLE_CYCLES(S), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a1), .b_o(b1), .cin_o(cin1), .sum_i(sum1), .cout_i(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: walk all operand combinations with plain integer arithmetic.
    function automatic exp_t model_run(input int t0);
        exp_t e;
        int n;
        int first;
        int last;
        n = 0;
        first = 0;
        last = NVEC - 1;
        for (int i = 0; i < NVEC; i++) begin
            int a;
            int b;
            int c;
            int good;
            int got;
            a = i / 32;
            b = (i / 2) % 16;
            c = i % 2;
            good = a + b + c;
            got = int'(env_adder(4'(a), 4'(b), 1'(c)));
            if (got != good) begin
                if (n == 0) first = i;
                n++;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
        e.t0   = t0;
        e.lat  = (S + 2) * (last + 1);
        e.err0 = (n > 1023) ? 1023 : n;
        e.err1 = (n > 255) ? 255 : n;
        e.ff   = first;
        e.vec  = last;
        e.pass = (n == 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: scores each completed sweep against the queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if ((busy0 && done0) || (busy1 && done1)) overlap++;
            if (exp_q.size() != 0 && !done0 && !busy0) busy_gap++;
            if (done0 && !done_prev && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                mon_last = e;
                check("latency", cyc - e.t0, e.lat);
                check("err_count", err0, e.err0);
                check("err_count_w8", err1, e.err1);
                check("first_fail", ff0, e.ff);
                check("first_fail_w8", ff1, e.ff);
                check("pass", pass0, e.pass);
                check("pass_w8", pass1, (e.err1 == 0) ? 1 : 0);
                check("done_w8", done1, 1);
                check("held_vector", {a0, b0, cin0}, e.vec);
                check("busy_through_sweep", busy_gap, 0);
                busy_gap = 0;
            end
            done_prev = done0;
        end
    end

    task automatic pulse_start(input bit expect_run);
        logic was_done;
        @(negedge clk);
        was_done = done0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_run) begin
            exp_q.push_back(model_run(cyc));
            if (was_done) begin
                check("done_drops_on_restart", done0, 0);
                check("busy_on_restart", busy0, 1);
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: done not seen within %0d cycles", k);
            exp_q.delete();
        end else begin
            repeat (3) @(negedge clk);
            check("done_held", done0, 1);
            check("err_held", err0, mon_last.err0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"}, {a0, b0, cin0}, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_pass"}, pass0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_first_fail"}, ff0, 0);
        check({tag, "_err_w8"}, err1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        fault_kind = 0; pulse_start(1'b1); wait_idle();
        fault_kind = 1; pulse_start(1'b1); wait_idle();
        fault_kind = 2; pulse_start(1'b1); wait_idle();

        for (int r = 0; r < 3; r++) begin
            fault_kind = 3 + int'($urandom_range(1, 0));
            f_bit = int'($urandom_range(4, 0));
            f_val = int'($urandom_range(1, 0));
            f_a = int'($urandom_range(15, 0));
            pulse_start(1'b1);
            wait_idle();
        end

        // Asynchronous reset in the middle of vector 100's settle window.
        fault_kind = 0;
        pulse_start(1'b1);
        k = 0;
        while ({a0, b0, cin0} != 9'd100 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached_idx100", {a0, b0, cin0}, 100);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_all_zero("async_reset");
        busy_gap = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        pulse_start(1'b1);
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        check("busy_done_exclusive", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
